// File: rtl/binario_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// A result is published with a one-cycle Listo pulse ANCHO cycles after the start is accepted.
module binario_bcd_secuencial #(
  parameter int ANCHO   = 8,
  parameter int DIGITOS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Inicio,
  input  logic [ANCHO-1:0]       DatoEntrada,
  output logic [4*DIGITOS-1:0]   DatoSalida,
  output logic                   Listo,
  output logic                   Ocupado,
  output logic                   Desborde
);

  localparam int BW = 4 * DIGITOS;
  localparam int CW = $clog2(ANCHO + 1);

  function automatic longint unsigned potencia10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Largest operand that still fits in DIGITOS decimal digits.
  localparam longint unsigned LIMITE = potencia10(DIGITOS) - 64'd1;

  function automatic logic [BW-1:0] ajuste(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITOS; i++)
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic [1:0] {REPOSO, CONVIRTIENDO, LISTO} estado_t;

  estado_t          estado, estado_sig;
  logic [BW-1:0]    scratch;
  logic [ANCHO-1:0] operando;
  logic [CW-1:0]    contador;
  logic             desborde_pend;
  logic [BW-1:0]    scratch_sig;
  logic [ANCHO-1:0] operando_sig;
  logic             arranque;
  logic             fin;

  // The adjusted scratch loses its top bit on the shift; truncation keeps value mod 10^DIGITOS.
  always_comb begin
    scratch_sig  = BW'({ajuste(scratch), operando[ANCHO-1]});
    operando_sig = {operando[ANCHO-2:0], 1'b0};
    fin          = (contador == CW'(1));
  end

  always_comb begin
    estado_sig = estado;
    arranque   = 1'b0;
    case (estado)
      REPOSO: begin
        if (Inicio) begin
          estado_sig = CONVIRTIENDO;
          arranque   = 1'b1;
        end
      end
      CONVIRTIENDO: begin
        if (fin) estado_sig = LISTO;
      end
      LISTO: begin
        if (Inicio) begin
          estado_sig = CONVIRTIENDO;
          arranque   = 1'b1;
        end else begin
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch       <= '0;
      operando      <= '0;
      contador      <= '0;
      desborde_pend <= 1'b0;
      DatoSalida    <= '0;
      Desborde      <= 1'b0;
    end else if (arranque) begin
      scratch       <= '0;
      operando      <= DatoEntrada;
      contador      <= CW'(ANCHO);
      desborde_pend <= (64'(DatoEntrada) > LIMITE);
    end else if (estado == CONVIRTIENDO) begin
      scratch  <= scratch_sig;
      operando <= operando_sig;
      contador <= contador - CW'(1);
      if (fin) begin
        DatoSalida <= scratch_sig;
        Desborde   <= desborde_pend;
      end
    end
  end

  assign Listo   = (estado == LISTO);
  assign Ocupado = (estado == CONVIRTIENDO);

endmodule

// File: tb/tb_binario_bcd_secuencial.sv
// Bench for binario_bcd_secuencial: a 3-digit and a 2-digit instance checked against
// an arithmetic (divide/modulo) BCD reference with directed and random operands.
module tb_binario_bcd_secuencial;

  logic        clk;
  logic        rst;
  logic        ini3, ini2;
  logic [7:0]  dat3, dat2;
  logic [11:0] out3;
  logic [7:0]  out2;
  logic        listo3, listo2, ocup3, ocup2, desb3, desb2;

  int checks = 0;
  int errors = 0;

  binario_bcd_secuencial #(.ANCHO(8), .DIGITOS(3)) dut3 (
    .clk(clk), .rst(rst), .Inicio(ini3), .DatoEntrada(dat3),
    .DatoSalida(out3), .Listo(listo3), .Ocupado(ocup3), .Desborde(desb3)
  );

  binario_bcd_secuencial #(.ANCHO(8), .DIGITOS(2)) dut2 (
    .clk(clk), .rst(rst), .Inicio(ini2), .DatoEntrada(dat2),
    .DatoSalida(out2), .Listo(listo2), .Ocupado(ocup2), .Desborde(desb2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  function automatic int pot10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] ref_bcd(input int v, input int d);
    int m;
    logic [11:0] r;
    m = v % pot10(d);
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ov(input int v, input int d);
    return (v > pot10(d) - 1);
  endfunction

  function automatic logic [11:0] out_s(input int sel);
    return (sel != 0) ? {4'b0, out2} : out3;
  endfunction

  function automatic logic listo_s(input int sel);
    return (sel != 0) ? listo2 : listo3;
  endfunction

  function automatic logic ocup_s(input int sel);
    return (sel != 0) ? ocup2 : ocup3;
  endfunction

  function automatic logic desb_s(input int sel);
    return (sel != 0) ? desb2 : desb3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic i, input logic [7:0] d);
    if (sel != 0) begin
      ini2 = i;
      dat2 = d;
    end else begin
      ini3 = i;
      dat3 = d;
    end
  endtask

  // modo: 0 quiet, 1 random Inicio/data while busy, 2 pulse Inicio=45 at cycle 3,
  // 3 leave Inicio high with 200 on the Listo cycle (back-to-back).
  task automatic run(input int sel, input int v, input int modo);
    int lat, ocup, d;
    logic [11:0] eo;
    logic eov;
    d   = (sel != 0) ? 2 : 3;
    eo  = ref_bcd(v, d);
    eov = ref_ov(v, d);
    drive(sel, 1'b1, 8'(v));
    @(negedge clk);
    lat  = 0;
    ocup = 0;
    while (!listo_s(sel) && lat < 20) begin
      if (ocup_s(sel)) ocup++;
      case (modo)
        1:       drive(sel, 1'($urandom_range(0, 1)), 8'($urandom));
        2:       drive(sel, (lat == 3), (lat == 3) ? 8'd45 : 8'd0);
        default: drive(sel, 1'b0, 8'd0);
      endcase
      @(negedge clk);
      lat++;
    end
    chk("latencia", 64'(lat), 64'd8);
    chk("ocupado", 64'(ocup), 64'd8);
    chk("salida", 64'(out_s(sel)), 64'(eo));
    chk("desborde", 64'(desb_s(sel)), 64'(eov));
    if (modo == 3) begin
      drive(sel, 1'b1, 8'd200);
    end else begin
      drive(sel, 1'b0, 8'd0);
      @(negedge clk);
      chk("pulso_listo", 64'(listo_s(sel)), 64'd0);
      chk("salida_retenida", 64'(out_s(sel)), 64'(eo));
    end
  endtask

  initial begin
    int cnt;
    clk  = 1'b0;
    rst  = 1'b1;
    ini3 = 1'b0; dat3 = 8'd0;
    ini2 = 1'b0; dat2 = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_salida3", 64'(out3), 64'd0);
    chk("rst_listo3", 64'(listo3), 64'd0);
    chk("rst_ocupado3", 64'(ocup3), 64'd0);
    chk("rst_desborde3", 64'(desb3), 64'd0);
    chk("rst_salida2", 64'(out2), 64'd0);
    chk("rst_listo2", 64'(listo2), 64'd0);
    rst = 1'b0;

    // Boundaries, with literal expectations alongside the model.
    run(0, 255, 0); chk("b255", 64'(out3), 64'h255);
    run(0, 0, 0);   chk("b0", 64'(out3), 64'h000);
    run(0, 9, 0);   chk("b9", 64'(out3), 64'h009);
    run(0, 10, 0);  chk("b10", 64'(out3), 64'h010);

    // Two-digit overflow cases.
    run(1, 99, 0);  chk("ov99", 64'(out2), 64'h99);  chk("ov99_d", 64'(desb2), 64'd0);
    run(1, 100, 0); chk("ov100", 64'(out2), 64'h00); chk("ov100_d", 64'(desb2), 64'd1);
    run(1, 200, 0); chk("ov200", 64'(out2), 64'h00); chk("ov200_d", 64'(desb2), 64'd1);

    // Start request while busy must be ignored; only one Listo follows.
    run(0, 123, 2);
    chk("ocupado_123", 64'(out3), 64'h123);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (listo3) cnt++;
    end
    chk("listo_unico", 64'(cnt), 64'd0);

    // Back-to-back: 57 then 200 accepted on the Listo cycle.
    run(0, 57, 3);
    chk("b2b_57", 64'(out3), 64'h057);
    @(negedge clk);
    drive(0, 1'b0, 8'd0);
    cnt = 1;
    while (!listo3 && cnt < 20) begin
      if (cnt == 4) chk("b2b_retiene", 64'(out3), 64'h057);
      @(negedge clk);
      cnt++;
    end
    chk("b2b_intervalo", 64'(cnt), 64'd9);
    chk("b2b_200", 64'(out3), 64'h200);
    @(negedge clk);

    // Reset mid-conversion aborts; the next start is accepted straight away.
    drive(0, 1'b1, 8'd250);
    @(negedge clk);
    drive(0, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_listo", 64'(listo3), 64'd0);
    chk("abort_ocupado", 64'(ocup3), 64'd0);
    chk("abort_salida", 64'(out3), 64'd0);
    chk("abort_desborde", 64'(desb3), 64'd0);
    run(0, 7, 0);
    chk("tras_rst_7", 64'(out3), 64'h007);

    // Every 8-bit operand on the 3-digit instance.
    for (int v = 0; v < 256; v++) run(0, v, 0);

    // Random operands, with random Inicio/data noise during conversion and idle gaps.
    for (int k = 0; k < 40; k++) begin
      run(0, int'($urandom_range(0, 255)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int k = 0; k < 30; k++) begin
      run(1, int'($urandom_range(0, 255)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
